// File: rtl/dlx_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, grant owner enum, default address/data widths.
package dlx_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-side, data-side and shared-memory signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req held until the matching one-cycle valid pulse; memory stalls via m_ack.
// Modports: slave = arbiter view (takes requests, drives memory);
//           master = environment view (CPU ports + memory model).
interface mem_arbiter_if
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  // instruction fetch side
  logic              i_req;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_data_read;
  logic              i_data_valid;
  // data side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_data_write;
  logic [DATA_W-1:0] d_data_read;
  logic              d_data_valid;
  // shared single-port memory
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_data_write;
  logic [DATA_W-1:0] m_data_read;
  logic              m_ack;
  // status
  logic              timeout_err;
  logic              busy;

  modport slave (
    input  i_req, i_address, d_req, d_we, d_address, d_data_write, m_data_read, m_ack,
    output i_data_read, i_data_valid, d_data_read, d_data_valid,
           m_req, m_we, m_address, m_data_write, timeout_err, busy
  );

  modport master (
    output i_req, i_address, d_req, d_we, d_address, d_data_write, m_data_read, m_ack,
    input  i_data_read, i_data_valid, d_data_read, d_data_valid,
           m_req, m_we, m_address, m_data_write, timeout_err, busy
  );

endinterface

// File: rtl/arb_timer.sv
// Wait-state counter for one memory access; flags the cycle that would make TIMEOUT waits.
// Latency: o_tc is combinational from the count and i_en (same cycle).
// Backpressure: none; i_clr wins over i_en.
// Ports: clk, reset_n (sync, active-low), i_clr (zero count), i_en (a wait cycle), o_tc (terminal).
module arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  // Count holds completed waits; the enabled cycle seen with TIMEOUT-1 of them is the TIMEOUT-th.
  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access.
// Latency: grant on the req edge, m_req next cycle, valid one cycle after m_ack (2 cycles minimum).
// Backpressure: m_ack stalls an access up to TIMEOUT wait cycles, then it aborts with timeout_err.
// Ports: clk, reset_n (sync, active-low), bus (mem_arbiter_if.slave: i_*, d_*, m_*, timeout_err, busy).
module mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);

  state_t            r_state, w_state_nxt;
  owner_t            r_last, w_last_nxt;
  logic              r_m_req, w_m_req_nxt;
  logic              r_m_we, w_m_we_nxt;
  logic [ADDR_W-1:0] r_m_addr, w_m_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata, w_m_wdata_nxt;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
  logic              r_i_vld, w_i_vld_nxt;
  logic              r_d_vld, w_d_vld_nxt;
  logic              r_tmo, w_tmo_nxt;
  logic              r_busy, w_busy_nxt;

  logic w_i_elig, w_d_elig;
  logic w_tmr_clr, w_tmr_en, w_tmr_tc;

  // A requester whose valid is showing this cycle is finishing; its held req is only new next cycle.
  assign w_i_elig = bus.i_req && !r_i_vld;
  assign w_d_elig = bus.d_req && !r_d_vld;

  // In a grant state m_req is always high, so wait cycles are simply granted cycles without ack.
  // Holding the counter clear while idle guarantees a fresh count on every grant.
  assign w_tmr_clr = (r_state == IDLE);
  assign w_tmr_en  = (r_state != IDLE) && !bus.m_ack;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_tc    (w_tmr_tc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_m_req_nxt   = r_m_req;
    w_m_we_nxt    = r_m_we;
    w_m_addr_nxt  = r_m_addr;
    w_m_wdata_nxt = r_m_wdata;
    w_i_rdata_nxt = r_i_rdata;
    w_d_rdata_nxt = r_d_rdata;
    w_i_vld_nxt   = 1'b0;
    w_d_vld_nxt   = 1'b0;
    w_tmo_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        // D wins when alone, or on a tie when I was granted last.
        if (w_d_elig && (!w_i_elig || r_last == OWN_I)) begin
          w_state_nxt   = GNT_D;
          w_last_nxt    = OWN_D;
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = bus.d_we;
          w_m_addr_nxt  = bus.d_address;
          w_m_wdata_nxt = bus.d_data_write;
        end else if (w_i_elig) begin
          w_state_nxt   = GNT_I;
          w_last_nxt    = OWN_I;
          w_m_req_nxt   = 1'b1;
          w_m_we_nxt    = 1'b0;
          w_m_addr_nxt  = bus.i_address;
          w_m_wdata_nxt = '0;
        end
      end

      GNT_I, GNT_D: begin
        // An ack on the last allowed wait cycle still counts as a normal completion.
        if (bus.m_ack) begin
          w_state_nxt = IDLE;
          w_m_req_nxt = 1'b0;
          if (r_state == GNT_I) begin
            w_i_vld_nxt   = 1'b1;
            w_i_rdata_nxt = bus.m_data_read;
          end else begin
            w_d_vld_nxt = 1'b1;
            if (!r_m_we) begin
              w_d_rdata_nxt = bus.m_data_read;
            end
          end
        end else if (w_tmr_tc) begin
          w_state_nxt = IDLE;
          w_m_req_nxt = 1'b0;
          w_tmo_nxt   = 1'b1;
          if (r_state == GNT_I) begin
            w_i_vld_nxt   = 1'b1;
            w_i_rdata_nxt = '0;
          end else begin
            w_d_vld_nxt   = 1'b1;
            w_d_rdata_nxt = '0;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_m_req_nxt = 1'b0;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_last    <= OWN_I;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_vld   <= 1'b0;
      r_d_vld   <= 1'b0;
      r_tmo     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_m_req   <= w_m_req_nxt;
      r_m_we    <= w_m_we_nxt;
      r_m_addr  <= w_m_addr_nxt;
      r_m_wdata <= w_m_wdata_nxt;
      r_i_rdata <= w_i_rdata_nxt;
      r_d_rdata <= w_d_rdata_nxt;
      r_i_vld   <= w_i_vld_nxt;
      r_d_vld   <= w_d_vld_nxt;
      r_tmo     <= w_tmo_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.m_req        = r_m_req;
  assign bus.m_we         = r_m_we;
  assign bus.m_address    = r_m_addr;
  assign bus.m_data_write = r_m_wdata;
  assign bus.i_data_read  = r_i_rdata;
  assign bus.i_data_valid = r_i_vld;
  assign bus.d_data_read  = r_d_rdata;
  assign bus.d_data_valid = r_d_vld;
  assign bus.timeout_err  = r_tmo;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic against a transaction model.
// Latency: checks every output 1 ns after each rising edge.
// Backpressure: the bench plays the memory and chooses when m_ack arrives.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int total = 0;
  int bad   = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the memory, how long it has waited, who won last.
  int          own;     // 0 nobody, 1 instruction side, 2 data side
  int          waits;
  bit          last_d;
  logic        e_mreq, e_mwe, e_ivld, e_dvld, e_tmo, e_busy;
  logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic ireq, input logic [31:0] iaddr,
                            input logic dreq, input logic dwe, input logic [31:0] daddr,
                            input logic [31:0] dwd, input logic mack, input logic [31:0] mrd);
    logic want_i, want_d;
    if (!rst_n) begin
      own = 0; waits = 0; last_d = 1'b0;
      e_mreq = 0; e_mwe = 0; e_ivld = 0; e_dvld = 0; e_tmo = 0; e_busy = 0;
      e_maddr = 0; e_mwdata = 0; e_irdata = 0; e_drdata = 0;
    end else begin
      want_i = ireq && !e_ivld;
      want_d = dreq && !e_dvld;
      e_ivld = 0; e_dvld = 0; e_tmo = 0;
      if (own == 0) begin
        if (want_d && (!want_i || !last_d)) begin
          own = 2; last_d = 1'b1; e_mwe = dwe; e_maddr = daddr; e_mwdata = dwd;
        end else if (want_i) begin
          own = 1; last_d = 1'b0; e_mwe = 1'b0; e_maddr = iaddr; e_mwdata = 0;
        end
        waits = 0;
      end else if (mack) begin
        if (own == 1) begin
          e_ivld = 1; e_irdata = mrd;
        end else begin
          e_dvld = 1;
          if (!e_mwe) e_drdata = mrd;
        end
        own = 0;
      end else begin
        waits++;
        if (waits == TMO) begin
          if (own == 1) begin e_ivld = 1; e_irdata = 0; end
          else          begin e_dvld = 1; e_drdata = 0; end
          e_tmo = 1;
          own = 0;
        end
      end
      e_mreq = (own != 0);
      e_busy = (own != 0);
    end
  endtask

  task automatic check_all();
    chk("m_req",        32'(bus.m_req),        32'(e_mreq));
    chk("m_we",         32'(bus.m_we),         32'(e_mwe));
    chk("m_address",    bus.m_address,         e_maddr);
    chk("m_data_write", bus.m_data_write,      e_mwdata);
    chk("i_data_read",  bus.i_data_read,       e_irdata);
    chk("i_data_valid", 32'(bus.i_data_valid), 32'(e_ivld));
    chk("d_data_read",  bus.d_data_read,       e_drdata);
    chk("d_data_valid", 32'(bus.d_data_valid), 32'(e_dvld));
    chk("timeout_err",  32'(bus.timeout_err),  32'(e_tmo));
    chk("busy",         32'(bus.busy),         32'(e_busy));
  endtask

  // One clock: capture the inputs the DUT will sample, advance, update the model, compare.
  task automatic tick();
    logic s_rst, s_ireq, s_dreq, s_dwe, s_mack;
    logic [31:0] s_iaddr, s_daddr, s_dwd, s_mrd;
    s_rst = reset_n; s_ireq = bus.i_req; s_iaddr = bus.i_address;
    s_dreq = bus.d_req; s_dwe = bus.d_we; s_daddr = bus.d_address; s_dwd = bus.d_data_write;
    s_mack = bus.m_ack; s_mrd = bus.m_data_read;
    @(posedge clk);
    #1;
    model_edge(s_rst, s_ireq, s_iaddr, s_dreq, s_dwe, s_daddr, s_dwd, s_mack, s_mrd);
    check_all();
  endtask

  initial begin
    bus.i_req = 0; bus.i_address = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_address = 0; bus.d_data_write = 0; bus.m_data_read = 0; bus.m_ack = 0;

    // reset state
    reset_n = 0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    reset_n = 1;
    tick();

    // instruction read, ack one cycle after m_req
    bus.i_req = 1; bus.i_address = 32'h40;
    tick();
    chk("r028_m_req", 32'(bus.m_req), 32'd1);
    chk("r028_m_addr", bus.m_address, 32'h40);
    bus.i_req = 0; bus.m_ack = 1; bus.m_data_read = 32'hDEADBEEF;
    tick();
    chk("r028_ivld", 32'(bus.i_data_valid), 32'd1);
    chk("r028_idata", bus.i_data_read, 32'hDEADBEEF);
    bus.m_ack = 0;
    tick();
    chk("r028_ivld_off", 32'(bus.i_data_valid), 32'd0);

    // data read; instruction word must stay put
    bus.d_req = 1; bus.d_we = 0; bus.d_address = 32'h200;
    tick();
    bus.d_req = 0; bus.m_ack = 1; bus.m_data_read = 32'hCAFEF00D;
    tick();
    chk("dread_data", bus.d_data_read, 32'hCAFEF00D);
    chk("dread_i_keep", bus.i_data_read, 32'hDEADBEEF);
    bus.m_ack = 0;
    tick();

    // data write; read register keeps previous value
    bus.d_req = 1; bus.d_we = 1; bus.d_address = 32'h100; bus.d_data_write = 32'h12345678;
    tick();
    chk("r030_m_we", 32'(bus.m_we), 32'd1);
    chk("r030_m_addr", bus.m_address, 32'h100);
    chk("r030_m_wd", bus.m_data_write, 32'h12345678);
    bus.d_req = 0; bus.d_we = 0; bus.m_ack = 1; bus.m_data_read = 32'hAAAA5555;
    tick();
    chk("r030_dvld", 32'(bus.d_data_valid), 32'd1);
    chk("r030_dkeep", bus.d_data_read, 32'hCAFEF00D);
    bus.m_ack = 0;
    tick();

    // data read that never gets an ack
    bus.d_req = 1; bus.d_address = 32'h300;
    tick();
    bus.d_req = 0;
    for (int k = 0; k < TMO - 1; k++) begin
      tick();
      chk("r031_wait_busy", 32'(bus.busy), 32'd1);
    end
    tick();
    chk("r031_dvld", 32'(bus.d_data_valid), 32'd1);
    chk("r031_ddata", bus.d_data_read, 32'd0);
    chk("r031_tmo", 32'(bus.timeout_err), 32'd1);
    tick();
    chk("r031_busy_next", 32'(bus.busy), 32'd0);
    chk("r031_tmo_off", 32'(bus.timeout_err), 32'd0);

    // ack arriving on the last allowed wait cycle completes normally
    bus.i_req = 1; bus.i_address = 32'h44;
    tick();
    bus.i_req = 0;
    for (int k = 0; k < TMO - 1; k++) tick();
    bus.m_ack = 1; bus.m_data_read = 32'h0BADCAFE;
    tick();
    chk("r022_ivld", 32'(bus.i_data_valid), 32'd1);
    chk("r022_no_tmo", 32'(bus.timeout_err), 32'd0);
    chk("r022_idata", bus.i_data_read, 32'h0BADCAFE);
    bus.m_ack = 0;
    tick();

    // reset two cycles into a stalled access, then a clean fetch
    bus.i_req = 1; bus.i_address = 32'h48;
    tick();
    bus.i_req = 0;
    tick(); tick();
    reset_n = 0;
    tick();
    chk("r032_m_req", 32'(bus.m_req), 32'd0);
    chk("r032_ivld", 32'(bus.i_data_valid), 32'd0);
    reset_n = 1;
    tick();
    bus.i_req = 1; bus.i_address = 32'h4C;
    tick();
    bus.i_req = 0; bus.m_ack = 1; bus.m_data_read = 32'h600DF00D;
    tick();
    chk("r032_idata", bus.i_data_read, 32'h600DF00D);
    bus.m_ack = 0;
    tick();

    // both sides held from reset with instant acks: D, I, D
    reset_n = 0;
    tick();
    reset_n = 1;
    bus.i_req = 1; bus.i_address = 32'h10;
    bus.d_req = 1; bus.d_we = 0; bus.d_address = 32'h20;
    bus.m_ack = 1; bus.m_data_read = 32'h11110000;
    tick();
    chk("r029_first_d", bus.m_address, 32'h20);
    tick();
    tick();
    chk("r029_then_i", bus.m_address, 32'h10);
    tick();
    tick();
    chk("r029_then_d", bus.m_address, 32'h20);
    bus.i_req = 0; bus.d_req = 0;
    tick();
    bus.m_ack = 0;
    tick();

    // random traffic, occasional reset
    for (int n = 0; n < 800; n++) begin
      reset_n           = ($urandom_range(0, 149) != 0);
      bus.i_req         = 1'($urandom_range(0, 1));
      bus.i_address     = $urandom;
      bus.d_req         = 1'($urandom_range(0, 1));
      bus.d_we          = 1'($urandom_range(0, 1));
      bus.d_address     = $urandom;
      bus.d_data_write  = $urandom;
      bus.m_ack         = ($urandom_range(0, 99) < 35);
      bus.m_data_read   = $urandom;
      tick();
    end
    reset_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
